// File: rtl/display_pkg.sv
// Shared constants and the 2x2 Bayer index helper for the colour-depth adapter.
package display_pkg;

    localparam int DITHER_NONE     = 0;
    localparam int DITHER_ORDERED  = 1;
    localparam int DITHER_TEMPORAL = 2;

    // Position {rp,cp} maps to 0,2,3,1; temporal mode rotates the index by the frame count.
    function automatic logic [1:0] bayer2x2(input logic rp, input logic cp,
                                            input logic [1:0] fc, input int mode);
        logic [1:0] idx;
        case ({rp, cp})
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd2;
            2'b10:   idx = 2'd3;
            default: idx = 2'd1;
        endcase
        if (mode == DITHER_TEMPORAL) begin
            idx = idx + fc;
        end else if (mode != DITHER_ORDERED) begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/dither_pos.sv
// Column/row parity and frame counter tracking; emits the Bayer index for the current pixel.
module dither_pos
    import display_pkg::*;
#(
    parameter int MODE = DITHER_ORDERED
) (
    input  logic       clk_pix,
    input  logic       rst_pix_n,
    input  logic       de,
    input  logic       frame,
    output logic [1:0] b
);

    logic       cp;
    logic       rp;
    logic       de_prev;
    logic [1:0] fc;

    // A frame pulse clears rp even when it lands on a de falling edge.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            cp      <= 1'b0;
            rp      <= 1'b0;
            de_prev <= 1'b0;
            fc      <= 2'd0;
        end else begin
            cp      <= de ? ~cp : 1'b0;
            de_prev <= de;
            if (frame) begin
                rp <= 1'b0;
                fc <= fc + 2'd1;
            end else if (de_prev && !de) begin
                rp <= ~rp;
            end
        end
    end

    assign b = bayer2x2(rp, cp, fc, MODE);

endmodule

// File: rtl/display_colour_adapt.sv
// Two-stage colour-depth adapter: widens by bit replication or narrows with optional dithering,
// keeping de/hsync/vsync aligned with the adapted pixel.
module display_colour_adapt
    import display_pkg::*;
#(
    parameter int BPC_IN   = 5,
    parameter int BPC_OUT  = 8,
    parameter int CHANNELS = 3,
    parameter int DITHER   = DITHER_ORDERED
) (
    input  logic                         clk_pix,
    input  logic                         rst_pix_n,
    input  logic                         disp_de,
    input  logic                         disp_hsync,
    input  logic                         disp_vsync,
    input  logic                         disp_frame,
    input  logic [CHANNELS*BPC_IN-1:0]   disp_din,
    output logic                         board_de,
    output logic                         board_hsync,
    output logic                         board_vsync,
    output logic [CHANNELS*BPC_OUT-1:0]  board_dout
);

    localparam int D  = BPC_IN - BPC_OUT;
    localparam int IW = CHANNELS * BPC_IN;
    localparam int OW = CHANNELS * BPC_OUT;

    logic [1:0]        b;
    logic [BPC_IN-1:0] t_next;
    logic [BPC_IN-1:0] d1_t;
    logic [IW-1:0]     d1_data;
    logic              d1_de;
    logic              d1_hsync;
    logic              d1_vsync;
    logic [OW-1:0]     dout_next;

    dither_pos #(.MODE(DITHER)) u_pos (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .de        (disp_de),
        .frame     (disp_frame),
        .b         (b)
    );

    // Scale the 2-bit index so its top bit lands just below the first kept output bit.
    generate
        if (D >= 2) begin : g_t_shift
            assign t_next = {{(BPC_IN-2){1'b0}}, b} << (D - 2);
        end else if (D == 1) begin : g_t_half
            assign t_next = {{(BPC_IN-1){1'b0}}, b[1]};
        end else begin : g_t_none
            assign t_next = '0;
        end
    endgenerate

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            d1_data  <= '0;
            d1_t     <= '0;
            d1_de    <= 1'b0;
            d1_hsync <= 1'b0;
            d1_vsync <= 1'b0;
        end else begin
            d1_data  <= disp_din;
            d1_t     <= t_next;
            d1_de    <= disp_de;
            d1_hsync <= disp_hsync;
            d1_vsync <= disp_vsync;
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [BPC_IN-1:0]  cin;
            logic [BPC_OUT-1:0] cout;

            assign cin = d1_data[c*BPC_IN +: BPC_IN];

            if (BPC_OUT > BPC_IN) begin : g_widen
                localparam int REP = (BPC_OUT + BPC_IN - 1) / BPC_IN;
                logic [REP*BPC_IN-1:0] rep;
                assign rep  = {REP{cin}};
                assign cout = rep[REP*BPC_IN-1 -: BPC_OUT];
            end else if (BPC_OUT == BPC_IN) begin : g_equal
                assign cout = cin;
            end else begin : g_narrow
                logic [BPC_IN:0]   sum;
                logic [BPC_IN-1:0] sat;
                // Saturate rather than wrap so bright pixels never flip to black.
                assign sum  = {1'b0, cin} + {1'b0, d1_t};
                assign sat  = sum[BPC_IN] ? {BPC_IN{1'b1}} : sum[BPC_IN-1:0];
                assign cout = sat[BPC_IN-1:D];
            end

            assign dout_next[c*BPC_OUT +: BPC_OUT] = cout;
        end
    endgenerate

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            board_de    <= 1'b0;
            board_hsync <= 1'b0;
            board_vsync <= 1'b0;
            board_dout  <= '0;
        end else begin
            board_de    <= d1_de;
            board_hsync <= d1_hsync;
            board_vsync <= d1_vsync;
            board_dout  <= d1_de ? dout_next : '0;
        end
    end

endmodule

// File: tb/tb_display_colour_adapt.sv
// Self-checking bench: widen 5->8, narrow 8->5 ordered and temporal, driven in lockstep
// from a vector table through a scoreboard queue, plus an asynchronous reset sequence.
module tb_display_colour_adapt;

    logic        clk_pix   = 1'b0;
    logic        rst_pix_n = 1'b0;
    logic        de        = 1'b0;
    logic        hs        = 1'b0;
    logic        vs        = 1'b0;
    logic        frame     = 1'b0;
    logic [14:0] din5      = '0;
    logic [23:0] din8      = '0;

    logic        w_de, w_hs, w_vs;
    logic [23:0] w_dout;
    logic        o_de, o_hs, o_vs;
    logic [14:0] o_dout;
    logic        t_de, t_hs, t_vs;
    logic [14:0] t_dout;

    typedef struct {
        logic        de, hs, vs, frame;
        logic [14:0] d5;
        logic [23:0] d8;
        logic [23:0] ew;
        logic [14:0] eo, et;
    } vec_t;

    typedef struct {
        int          id;
        logic        de, hs, vs;
        logic [23:0] ew;
        logic [14:0] eo, et;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk_pix = ~clk_pix;

    display_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .CHANNELS(3), .DITHER(1)) u_widen (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .disp_de(de), .disp_hsync(hs),
        .disp_vsync(vs), .disp_frame(frame), .disp_din(din5),
        .board_de(w_de), .board_hsync(w_hs), .board_vsync(w_vs), .board_dout(w_dout)
    );

    display_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANNELS(3), .DITHER(1)) u_ord (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .disp_de(de), .disp_hsync(hs),
        .disp_vsync(vs), .disp_frame(frame), .disp_din(din8),
        .board_de(o_de), .board_hsync(o_hs), .board_vsync(o_vs), .board_dout(o_dout)
    );

    display_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANNELS(3), .DITHER(2)) u_tmp (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .disp_de(de), .disp_hsync(hs),
        .disp_vsync(vs), .disp_frame(frame), .disp_din(din8),
        .board_de(t_de), .board_hsync(t_hs), .board_vsync(t_vs), .board_dout(t_dout)
    );

    function automatic vec_t mk(input logic v_de, v_hs, v_vs, v_fr,
                                input logic [14:0] d5, input logic [23:0] d8,
                                input logic [23:0] ew, input logic [14:0] eo, et);
        vec_t v;
        v.de = v_de; v.hs = v_hs; v.vs = v_vs; v.frame = v_fr;
        v.d5 = d5; v.d8 = d8; v.ew = ew; v.eo = eo; v.et = et;
        return v;
    endfunction

    task automatic checkValue(input string name, input int id,
                              input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s vec=%0d got=%h expected=%h", name, id, got, want);
        end
    endtask

    // Output for a pixel is visible one negedge after the second edge following its drive.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 2) begin
            e = sb.pop_front();
            checkValue("w_de",   e.id, 24'(w_de),   24'(e.de));
            checkValue("w_hs",   e.id, 24'(w_hs),   24'(e.hs));
            checkValue("w_vs",   e.id, 24'(w_vs),   24'(e.vs));
            checkValue("o_de",   e.id, 24'(o_de),   24'(e.de));
            checkValue("t_vs",   e.id, 24'(t_vs),   24'(e.vs));
            checkValue("w_dout", e.id, w_dout,      e.ew);
            checkValue("o_dout", e.id, 24'(o_dout), 24'(e.eo));
            checkValue("t_dout", e.id, 24'(t_dout), 24'(e.et));
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int id);
        exp_t e;
        @(negedge clk_pix);
        checkOutput();
        de = v.de; hs = v.hs; vs = v.vs; frame = v.frame;
        din5 = v.d5; din8 = v.d8;
        e.id = id; e.de = v.de; e.hs = v.hs; e.vs = v.vs;
        e.ew = v.ew; e.eo = v.eo; e.et = v.et;
        sb.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, "_w_de"},   0, 24'(w_de),   24'h0);
        checkValue({tag, "_w_hs"},   0, 24'(w_hs),   24'h0);
        checkValue({tag, "_w_vs"},   0, 24'(w_vs),   24'h0);
        checkValue({tag, "_w_dout"}, 0, w_dout,      24'h0);
        checkValue({tag, "_o_dout"}, 0, 24'(o_dout), 24'h0);
        checkValue({tag, "_t_dout"}, 0, 24'(t_dout), 24'h0);
    endtask

    task automatic idleInputs();
        de = 1'b0; hs = 1'b0; vs = 1'b0; frame = 1'b0; din5 = '0; din8 = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // de hs vs fr  d5        d8           widen      ordered   temporal
        tbl.push_back(mk(1,0,0,0, 15'h7E00, 24'hFE0503, 24'hFF8400, 15'h7C00, 15'h7C00));
        tbl.push_back(mk(1,0,0,0, 15'h003F, 24'h050505, 24'h0008FF, 15'h0421, 15'h0421));
        tbl.push_back(mk(1,0,0,0, 15'h2AA3, 24'h050505, 24'h52AD18, 15'h0000, 15'h0000));
        tbl.push_back(mk(1,0,0,0, 15'h7E00, 24'h050505, 24'hFF8400, 15'h0421, 15'h0421));
        tbl.push_back(mk(0,1,0,0, 15'h7FFF, 24'hFFFFFF, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(0,1,0,0, 15'h7FFF, 24'hFFFFFF, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(0,0,0,0, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(1,0,0,0, 15'h0000, 24'h050505, 24'h000000, 15'h0421, 15'h0421));
        tbl.push_back(mk(1,0,0,0, 15'h7FFF, 24'h050505, 24'hFFFFFF, 15'h0000, 15'h0000));
        tbl.push_back(mk(1,0,0,0, 15'h0000, 24'hFEFEFE, 24'h000000, 15'h7FFF, 15'h7FFF));
        tbl.push_back(mk(1,0,0,0, 15'h0000, 24'h050505, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(0,0,1,1, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(0,0,1,0, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(1,0,0,0, 15'h7E00, 24'h060606, 24'hFF8400, 15'h0000, 15'h0421));
        tbl.push_back(mk(0,0,0,1, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(1,0,0,0, 15'h0000, 24'h040404, 24'h000000, 15'h0000, 15'h0421));
        tbl.push_back(mk(0,0,0,1, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(1,0,0,0, 15'h0000, 24'h030303, 24'h000000, 15'h0000, 15'h0421));
        tbl.push_back(mk(0,0,0,1, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(1,0,0,0, 15'h0000, 24'h030303, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(0,0,0,0, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000));
        tbl.push_back(mk(0,0,0,0, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000));

        repeat (3) @(negedge clk_pix);
        checkAllZero("reset");
        rst_pix_n = 1'b1;

        foreach (tbl[i]) applyStimulus(tbl[i], i);

        // Build up cp=1, rp=1, fc=1 with live outputs, then reset between clock edges.
        applyStimulus(mk(0,0,0,1, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000), 100);
        applyStimulus(mk(1,0,0,0, 15'h7E00, 24'h050505, 24'hFF8400, 15'h0000, 15'h0000), 101);
        applyStimulus(mk(0,0,0,0, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000), 102);
        applyStimulus(mk(1,0,0,0, 15'h7E00, 24'h050505, 24'hFF8400, 15'h0421, 15'h0000), 103);
        applyStimulus(mk(1,1,1,0, 15'h7E00, 24'h050505, 24'hFF8400, 15'h0000, 15'h0421), 104);
        applyStimulus(mk(1,0,0,0, 15'h7E00, 24'h050505, 24'hFF8400, 15'h0421, 15'h0000), 105);
        @(negedge clk_pix);
        checkOutput();
        #2 rst_pix_n = 1'b0;
        #1 checkAllZero("async_rst");
        sb.delete();
        idleInputs();
        @(posedge clk_pix);
        #1 checkAllZero("held_rst");
        #1 rst_pix_n = 1'b1;

        applyStimulus(mk(1,0,0,0, 15'h7E00, 24'h060606, 24'hFF8400, 15'h0000, 15'h0000), 200);
        applyStimulus(mk(1,0,0,0, 15'h0000, 24'h050505, 24'h000000, 15'h0421, 15'h0421), 201);
        applyStimulus(mk(0,0,0,0, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000), 202);
        applyStimulus(mk(0,0,0,0, 15'h0000, 24'h000000, 24'h000000, 15'h0000, 15'h0000), 203);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
